alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the execute-stage combinational ALU.
- Covers the full RV32I/RV64I register-register ALU op set: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Shift amount is variable, taken from aluin2, and executed by an iterative shifter moving SHAMT_STEP bits per cycle.
- Operands enter and results leave through valid/ready handshakes, so the core pipeline can stall on long shifts.

---
 rtl/alu_mc.sv | 149 ++++++++++++++
 tb/tb_alu_mc.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I/RV64I register-register ALU.
// Non-shift ops finish one edge after accept. Shifts run on an iterative
// shifter that moves SHAMT_STEP bits per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand/op bundle handshake (in_ready only in IDLE)
//   aluin1, aluin2        operands; aluin2[SHW-1:0] is the shift amount
//   funct3, funct7        RISC-V funct3 and funct7 bit 5
//   out_valid / out_ready result handshake
//   aluout, illegal       result and unsupported-op flag (qualified by out_valid)
module alu_mc #(
    parameter int XLEN       = 32,
    parameter int SHAMT_STEP = 1,
    parameter int SHW        = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] aluin1,
    input  logic [XLEN-1:0] aluin2,
    input  logic [2:0]      funct3,
    input  logic            funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] aluout,
    output logic            illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHW:0] STEPW = (SHW+1)'(SHAMT_STEP);

    state_t          state, state_nx;
    logic [XLEN-1:0] sreg;
    logic [SHW-1:0]  cnt;
    logic            sh_left, sh_arith;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] res;
    logic            ill, is_shift;
    logic [SHW-1:0]  k, cnt_nx;
    logic [XLEN-1:0] shifted;

    assign accept = in_valid && in_ready;
    assign shamt  = aluin2[SHW-1:0];

    // Op decode on the live inputs; only used at the accept edge.
    always_comb begin
        res      = '0;
        ill      = 1'b0;
        is_shift = 1'b0;
        case ({funct7, funct3})
            4'b0000: res = aluin1 + aluin2;
            4'b1000: res = aluin1 - aluin2;
            4'b0010: res = {{(XLEN-1){1'b0}}, $signed(aluin1) < $signed(aluin2)};
            4'b0011: res = {{(XLEN-1){1'b0}}, aluin1 < aluin2};
            4'b0100: res = aluin1 ^ aluin2;
            4'b0110: res = aluin1 | aluin2;
            4'b0111: res = aluin1 & aluin2;
            4'b0001, 4'b0101, 4'b1101: begin
                is_shift = 1'b1;
                res      = aluin1;
            end
            default: ill = 1'b1;
        endcase
    end

    // One shifter step of min(SHAMT_STEP, cnt) bits. sreg keeps its sign
    // bit under SRA, so the arithmetic fill is always the original sign.
    always_comb begin
        k = ({1'b0, cnt} >= STEPW) ? STEPW[SHW-1:0] : cnt;
        cnt_nx = cnt - k;
        if (sh_left)
            shifted = sreg << k;
        else if (sh_arith)
            shifted = $signed(sreg) >>> k;
        else
            shifted = sreg >> k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept)
                    state_nx = (is_shift && shamt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt_nx == '0)
                    state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shifting happens in sreg; aluout is only loaded on DONE entry so it
    // stays stable for the whole SHIFT phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluout   <= '0;
            illegal  <= 1'b0;
            sreg     <= '0;
            cnt      <= '0;
            sh_left  <= 1'b0;
            sh_arith <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        illegal  <= ill;
                        sh_left  <= (funct3 == 3'b001);
                        sh_arith <= funct7;
                        if (is_shift && shamt != '0) begin
                            sreg <= aluin1;
                            cnt  <= shamt;
                        end else begin
                            aluout <= res;
                        end
                    end
                end
                SHIFT: begin
                    sreg <= shifted;
                    cnt  <= cnt_nx;
                    if (cnt_nx == '0)
                        aluout <= shifted;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    localparam int XLEN = 32;
    localparam int STEP = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] aluin1 = '0;
    logic [XLEN-1:0] aluin2 = '0;
    logic [2:0]      funct3 = '0;
    logic            funct7 = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] aluout;
    logic            illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mc #(.XLEN(XLEN), .SHAMT_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluin1(aluin1), .aluin2(aluin2),
        .funct3(funct3), .funct7(funct7),
        .out_valid(out_valid), .out_ready(out_ready),
        .aluout(aluout), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model straight from the op table.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic f7, output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        r   = 32'h0;
        case ({f7, f3})
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0001: begin r = a << sh; lat = 1 + (sh + STEP - 1) / STEP; end
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0100: r = a ^ b;
            4'b0101: begin r = a >> sh; lat = 1 + (sh + STEP - 1) / STEP; end
            4'b1101: begin r = 32'($signed(a) >>> sh); lat = 1 + (sh + STEP - 1) / STEP; end
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: ill = 1'b1;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic f7, input int stall);
        logic [31:0] er;
        logic        eill;
        int          elat;
        int          lat;
        logic        bad;
        model(a, b, f3, f7, er, eill, elat);
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        aluin1 = a; aluin2 = b; funct3 = f3; funct7 = f7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        aluin1 = $urandom; aluin2 = $urandom;
        funct3 = 3'($urandom); funct7 = 1'($urandom);
        lat = 1;
        bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, ".in_ready_busy"}, 64'(bad), 64'd0);
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".illegal"}, 64'(illegal), 64'(eill));
        check({tag, ".aluout"}, 64'(aluout), 64'(er));
        bad = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || aluout !== er || illegal !== eill) bad = 1'b1;
        end
        if (stall > 0) check({tag, ".hold"}, 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".out_valid_clear"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic seen;
        repeat (3) @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.aluout", 64'(aluout), 64'd0);
        check("rst.illegal", 64'(illegal), 64'd0);
        rst_n = 1'b1;

        run_op("add_wrap", 32'hFFFF_FFFF, 32'h1, 3'b000, 1'b0, 0);
        run_op("sub_wrap", 32'h0, 32'h1, 3'b000, 1'b1, 0);
        run_op("slt", 32'hFFFF_FFFF, 32'h1, 3'b010, 1'b0, 0);
        run_op("sltu", 32'hFFFF_FFFF, 32'h1, 3'b011, 1'b0, 0);
        run_op("sra5", 32'h8000_0000, 32'h25, 3'b101, 1'b1, 0);
        run_op("srl5", 32'h8000_0000, 32'h25, 3'b101, 1'b0, 0);
        run_op("or_bp", 32'hF0F0_0000, 32'h0000_0F0F, 3'b110, 1'b0, 5);
        run_op("ill", 32'h1234, 32'h5, 3'b001, 1'b1, 2);
        run_op("sll0", 32'h1234, 32'hFFFF_FFE0, 3'b001, 1'b0, 0);
        run_op("sll31", 32'h1, 32'd31, 3'b001, 1'b0, 1);
        run_op("sra31", 32'h8000_0001, 32'd31, 3'b101, 1'b1, 0);

        // Reset in the middle of a long shift.
        @(negedge clk);
        in_valid = 1'b1;
        aluin1 = 32'h1; aluin2 = 32'd31; funct3 = 3'b001; funct7 = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.aluout", 64'(aluout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        out_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("midrst.no_late_result", 64'(seen), 64'd0);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if (n % 4 == 0) b = b & 32'h0000_00FF;
            if (n % 7 == 0) a = 32'h8000_0000 | a;
            run_op("rnd", a, b, 3'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
